// File: rtl/data_mem_seq.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_seq
// Description : Parametrised single-port data memory for the custom CPU.
//               After reset, a small sequencer clears one word per cycle. It
//               then optionally writes the constant table (LFSR tap patterns,
//               space and delimiter characters), one entry per cycle. When
//               that finishes it raises Ready. Read latency is 0 (combinational)
//               or 1 (registered, read-first).
// Ports       : Clk         - clock
//               Reset       - synchronous active-high reset
//               WriteEn     - CPU write strobe, honoured only while Ready=1
//               DataAddress - CPU read/write address (AW bits)
//               DataIn      - CPU write data (W bits)
//               DataOut     - read data, forced to 0 while not Ready
//               Ready       - high once initialisation has completed
//               WrIgnored   - one-cycle pulse after a dropped CPU write
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_seq #(
    parameter int W          = 8,
    parameter int AW         = 8,
    parameter int RD_LAT     = 0,
    parameter int PRELOAD_EN = 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          WriteEn,
    input  logic [AW-1:0] DataAddress,
    input  logic [W-1:0]  DataIn,
    output logic [W-1:0]  DataOut,
    output logic          Ready,
    output logic          WrIgnored
);

    localparam int            DEPTH     = 2**AW;
    localparam logic [AW-1:0] LAST_PTR  = {AW{1'b1}};
    localparam logic [3:0]    LAST_IDX  = 4'd10;

    localparam logic [1:0]    S_CLEAR   = 2'd0;
    localparam logic [1:0]    S_PRELOAD = 2'd1;
    localparam logic [1:0]    S_READY   = 2'd2;

    logic [W-1:0]  core [0:DEPTH-1];

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] ptr_q,   ptr_d;
    logic [3:0]    idx_q,   idx_d;
    logic          ready_q, ready_d;
    logic          wr_ign_q, wr_ign_d;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;

    logic [7:0]    tbl_addr;
    logic [7:0]    tbl_val;
    logic          tbl_in_range;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_CLEAR;
            ptr_q    <= '0;
            idx_q    <= '0;
            ready_q  <= 1'b0;
            wr_ign_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            ready_q  <= ready_d;
            wr_ign_q <= wr_ign_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        case (state_q)
            S_CLEAR: begin
                // ptr wraps back to 0 exactly when leaving CLEAR
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == LAST_PTR) begin
                    state_d = (PRELOAD_EN != 0) ? S_PRELOAD : S_READY;
                end
            end
            S_PRELOAD: begin
                idx_d = idx_q + 4'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                state_d = S_READY;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Constant table: entry idx -> (address, value). Address 139 is skipped.
    // ------------------------------------------------------------------
    always_comb begin
        tbl_addr = 8'd141;
        tbl_val  = 8'h00;
        case (idx_q)
            4'd0:    begin tbl_addr = 8'd130; tbl_val = 8'h60; end
            4'd1:    begin tbl_addr = 8'd131; tbl_val = 8'h48; end
            4'd2:    begin tbl_addr = 8'd132; tbl_val = 8'h78; end
            4'd3:    begin tbl_addr = 8'd133; tbl_val = 8'h72; end
            4'd4:    begin tbl_addr = 8'd134; tbl_val = 8'h6A; end
            4'd5:    begin tbl_addr = 8'd135; tbl_val = 8'h69; end
            4'd6:    begin tbl_addr = 8'd136; tbl_val = 8'h5C; end
            4'd7:    begin tbl_addr = 8'd137; tbl_val = 8'h7E; end
            4'd8:    begin tbl_addr = 8'd138; tbl_val = 8'h7B; end
            4'd9:    begin tbl_addr = 8'd140; tbl_val = 8'h20; end
            default: begin tbl_addr = 8'd141; tbl_val = 8'h00; end
        endcase
        // Entries beyond a small memory still consume their cycle
        tbl_in_range = (int'(tbl_addr) < DEPTH);
    end

    // ------------------------------------------------------------------
    // Output logic: memory write port, Ready and WrIgnored
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = ptr_q;
        mem_wdata = '0;
        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = ptr_q;
                mem_wdata = '0;
            end
            S_PRELOAD: begin
                mem_we    = tbl_in_range;
                mem_addr  = AW'(tbl_addr);
                mem_wdata = W'(tbl_val);
            end
            S_READY: begin
                mem_we    = WriteEn;
                mem_addr  = DataAddress;
                mem_wdata = DataIn;
            end
            default: begin
                mem_we    = 1'b0;
            end
        endcase
        // Ready registers the entry into READY so it rises on that same edge
        ready_d  = (state_d == S_READY);
        wr_ign_d = WriteEn && !ready_q;
    end

    // Memory keeps its contents while Reset is held
    always_ff @(posedge Clk) begin
        if (!Reset && mem_we) begin
            core[mem_addr] <= mem_wdata;
        end
    end

    assign Ready     = ready_q;
    assign WrIgnored = wr_ign_q;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    generate
        if (RD_LAT == 0) begin : g_rd_comb
            assign DataOut = ready_q ? core[DataAddress] : '0;
        end else begin : g_rd_reg
            logic [W-1:0] dout_q, dout_d;

            // Array read happens before the edge's write lands: read-first
            always_comb begin
                dout_d = ready_q ? core[DataAddress] : '0;
            end

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    dout_q <= '0;
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign DataOut = dout_q;
        end
    endgenerate

endmodule
`default_nettype wire
